// File: rtl/mtf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mtf_pkg
// Description : Shared constants and helpers for the move-to-front decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package mtf_pkg;

  // Symbol kind carried on sym_is_lit_in
  localparam logic SYM_IDX = 1'b0;
  localparam logic SYM_LIT = 1'b1;

  // Widest match vector the priority encoder handles (NUM must not exceed it)
  localparam int c_max_num = 32;

  // Lowest set bit position of vec; 0 when no bit is set
  function automatic int first_set(input logic [c_max_num-1:0] vec);
    int pos;
    pos = 0;
    for (int i = c_max_num - 1; i >= 0; i--) begin
      if (vec[i]) pos = i;
    end
    return pos;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mtf_table.sv
`default_nettype none
// ============================================================================
// Module      : mtf_table
// Description : Recency table of the last NUM unique values with match,
//               move-to-front shift, flush and an indexed read port.
// Revision    : 1.0 - initial release
// ============================================================================
module mtf_table
  import mtf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NUM   = 4,
  parameter int IDX_W = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 clear_in,
  input  logic                 upd_en_in,
  input  logic [WIDTH-1:0]     upd_val_in,
  input  logic [IDX_W-1:0]     rd_idx_in,
  output logic [WIDTH-1:0]     rd_data_out,
  output logic                 rd_valid_out,
  output logic                 hit_out,
  output logic [IDX_W-1:0]     hit_pos_out,
  output logic [NUM*WIDTH-1:0] table_out,
  output logic [NUM-1:0]       table_valid_out
);

  logic [NUM-1:0][WIDTH-1:0] r_entry;
  logic [NUM-1:0]            r_valid;
  logic [NUM-1:0]            w_match;
  logic                      w_hit;
  logic [IDX_W-1:0]          w_hit_pos;

  // Only valid entries may match, so stale data left behind by a flush never hits
  generate
    for (genvar g = 0; g < NUM; g++) begin : g_match
      assign w_match[g] = r_valid[g] && (r_entry[g] == upd_val_in);
    end
  endgenerate

  assign w_hit     = |w_match;
  assign w_hit_pos = IDX_W'(first_set(32'(w_match)));

  // Indexed read; indices beyond the table read as invalid
  always_comb begin
    rd_data_out  = '0;
    rd_valid_out = 1'b0;
    for (int j = 0; j < NUM; j++) begin
      if (rd_idx_in == IDX_W'(j)) begin
        rd_data_out  = r_entry[j];
        rd_valid_out = r_valid[j];
      end
    end
  end

  // Table update: flush wins, otherwise move the value to the front
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_entry <= '0;
      r_valid <= '0;
    end else if (clear_in) begin
      r_valid <= '0;
    end else if (upd_en_in) begin
      // On a hit only entries up to the hit slot slide back; on a miss all do
      for (int j = NUM - 1; j >= 1; j--) begin
        if (!w_hit || (IDX_W'(j) <= w_hit_pos)) r_entry[j] <= r_entry[j-1];
      end
      r_entry[0] <= upd_val_in;
      if (!w_hit) r_valid <= {r_valid[NUM-2:0], 1'b1};
    end
  end

  assign hit_out         = w_hit;
  assign hit_pos_out     = w_hit_pos;
  assign table_out       = r_entry;
  assign table_valid_out = r_valid;

endmodule
`default_nettype wire

// File: rtl/mtf_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mtf_decoder
// Description : Move-to-front decoder. Turns literal/index symbols back into
//               data values and drives them on a registered valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module mtf_decoder
  import mtf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NUM   = 4,
  parameter int IDX_W = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 clear_in,
  input  logic                 sym_valid_in,
  output logic                 sym_ready_out,
  input  logic                 sym_is_lit_in,
  input  logic [IDX_W-1:0]     sym_idx_in,
  input  logic [WIDTH-1:0]     sym_lit_in,
  output logic [WIDTH-1:0]     data_out,
  output logic                 data_valid_out,
  input  logic                 data_ready_in,
  output logic [NUM*WIDTH-1:0] table_out,
  output logic [NUM-1:0]       table_valid_out,
  output logic                 err_out
);

  logic [WIDTH-1:0] r_data;
  logic             r_data_valid;
  logic             r_err;

  logic             w_accept;
  logic             w_is_idx;
  logic             w_bad;
  logic             w_beat;
  logic [WIDTH-1:0] w_value;
  logic [WIDTH-1:0] w_rd_data;
  logic             w_rd_valid;
  logic             w_hit;
  logic [IDX_W-1:0] w_hit_pos;
  logic             w_unused;

  // A symbol can enter whenever the output slot is empty or draining this cycle
  assign sym_ready_out = !r_data_valid || data_ready_in;
  assign w_accept      = sym_valid_in && sym_ready_out;

  // Index symbols read the table before this edge's update; bad indices yield no beat
  assign w_is_idx = (sym_is_lit_in == SYM_IDX);
  assign w_value  = w_is_idx ? w_rd_data : sym_lit_in;
  assign w_bad    = w_is_idx && !w_rd_valid;
  assign w_beat   = w_accept && !w_bad;

  mtf_table #(
    .WIDTH (WIDTH),
    .NUM   (NUM),
    .IDX_W (IDX_W)
  ) u_table (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .clear_in        (clear_in),
    .upd_en_in       (w_beat),
    .upd_val_in      (w_value),
    .rd_idx_in       (sym_idx_in),
    .rd_data_out     (w_rd_data),
    .rd_valid_out    (w_rd_valid),
    .hit_out         (w_hit),
    .hit_pos_out     (w_hit_pos),
    .table_out       (table_out),
    .table_valid_out (table_valid_out)
  );

  // Hit status is not needed here: an index symbol always hits its own slot
  assign w_unused = &{1'b0, w_hit, w_hit_pos};

  // Output register: load on a decoded beat, drop valid once the beat is taken
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_data       <= '0;
      r_data_valid <= 1'b0;
    end else if (w_beat) begin
      r_data       <= w_value;
      r_data_valid <= 1'b1;
    end else if (data_ready_in) begin
      r_data_valid <= 1'b0;
    end
  end

  // Sticky error: set by any accepted index that points at an invalid slot
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_err <= 1'b0;
    end else if (w_accept && w_bad) begin
      r_err <= 1'b1;
    end
  end

  assign data_out       = r_data;
  assign data_valid_out = r_data_valid;
  assign err_out        = r_err;

endmodule
`default_nettype wire
